// File: rtl/readout_arbiter.sv
// readout_arbiter: shares one 64-bit FIFO write port among N_SRC event savers.
// Round-robin grant of one whole event (header + data words) at a time, only
// when the FIFO can hold a full event, followed by a fixed dead time.
module readout_arbiter #(
  parameter int N_SRC           = 4,
  parameter int WORDS_PER_EVENT = 16,
  parameter int DEAD_TIME       = 8,
  parameter int TIMEOUT         = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       req_i,
  input  logic [N_SRC-1:0]       src_wr_en_i,
  input  logic [N_SRC-1:0][63:0] src_din_i,
  input  logic                   fifo_prog_full_i,
  output logic [N_SRC-1:0]       grant_o,
  output logic                   fifo_wr_en_o,
  output logic [63:0]            fifo_din_o,
  output logic                   busy_o,
  output logic [15:0]            event_cnt_o,
  output logic [15:0]            drop_cnt_o,
  output logic                   timeout_err_o
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int WC_W  = $clog2(WORDS_PER_EVENT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(DEAD_TIME + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_STREAM,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [31:0]      r_ts;
  logic [31:0]      r_ts_lat;
  logic [15:0]      r_evt_cnt;
  logic [15:0]      r_drop_cnt;
  logic             r_terr;
  logic [N_SRC-1:0] r_grant;
  logic             r_wr_en;
  logic [63:0]      r_din;
  logic [WC_W-1:0]  r_wc;
  logic [TO_W-1:0]  r_to;
  logic [GAP_W-1:0] r_gap;

  state_t           w_state_next;
  logic [SEL_W-1:0] w_sel_next;
  logic [SEL_W-1:0] w_rr_ptr_next;
  logic [31:0]      w_ts_lat_next;
  logic [15:0]      w_evt_next;
  logic             w_terr_next;
  logic [N_SRC-1:0] w_grant_next;
  logic             w_wr_en_next;
  logic [63:0]      w_din_next;
  logic [WC_W-1:0]  w_wc_next;
  logic [TO_W-1:0]  w_to_next;
  logic [GAP_W-1:0] w_gap_next;

  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W:0]   w_rr_cand;
  logic [SEL_W-1:0] w_sel_inc;
  logic [N_SRC-1:0] w_sel_onehot;
  logic [N_SRC-1:0] w_drop_bits;
  logic [4:0]       w_drop_pop;
  logic [16:0]      w_drop_sum;
  logic [15:0]      w_drop_next;

  assign grant_o       = r_grant;
  assign fifo_wr_en_o  = r_wr_en;
  assign fifo_din_o    = r_din;
  assign busy_o        = (r_state != S_IDLE);
  assign event_cnt_o   = r_evt_cnt;
  assign drop_cnt_o    = r_drop_cnt;
  assign timeout_err_o = r_terr;

  // Per-channel decode: one-hot of the selected channel and dropped strobes.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_chan
      assign w_sel_onehot[gi] = (r_sel == SEL_W'(gi));
      assign w_drop_bits[gi]  = src_wr_en_i[gi] & ~r_grant[gi];
    end
  endgenerate

  // Next round-robin pointer after the current event.
  assign w_sel_inc = (r_sel == SEL_W'(N_SRC - 1)) ? '0 : r_sel + 1'b1;

  // Round-robin pick: first requester at or after r_rr_ptr; the downward scan
  // lets the smallest offset win.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_cand  = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      w_rr_cand = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
      if (w_rr_cand >= (SEL_W + 1)'(N_SRC)) begin
        w_rr_cand = w_rr_cand - (SEL_W + 1)'(N_SRC);
      end
      if (req_i[w_rr_cand[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_cand[SEL_W-1:0];
      end
    end
  end

  // Drop counter: add strobes from non-granted channels, saturating.
  always_comb begin
    w_drop_pop = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_drop_pop = w_drop_pop + 5'(w_drop_bits[k]);
    end
    w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drop_pop);
    w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  // FSM next state plus next values of every registered output.
  always_comb begin
    w_state_next  = r_state;
    w_sel_next    = r_sel;
    w_rr_ptr_next = r_rr_ptr;
    w_ts_lat_next = r_ts_lat;
    w_evt_next    = r_evt_cnt;
    w_terr_next   = r_terr;
    w_grant_next  = r_grant;
    w_wr_en_next  = 1'b0;
    w_din_next    = r_din;
    w_wc_next     = r_wc;
    w_to_next     = r_to;
    w_gap_next    = r_gap;
    unique case (r_state)
      S_IDLE: begin
        // Admission only when the FIFO can take the whole event.
        if (w_rr_found && !fifo_prog_full_i) begin
          w_sel_next    = w_rr_idx;
          w_ts_lat_next = r_ts;
          w_state_next  = S_HEADER;
        end
      end
      S_HEADER: begin
        w_wr_en_next = 1'b1;
        w_din_next   = {4'hA, 4'(r_sel), 8'h00, r_evt_cnt, r_ts_lat};
        w_evt_next   = r_evt_cnt + 16'd1;
        w_grant_next = w_sel_onehot;
        w_wc_next    = '0;
        w_to_next    = '0;
        w_state_next = S_STREAM;
      end
      S_STREAM: begin
        // FIFO fullness is not re-checked here; admission already reserved room.
        if (src_wr_en_i[r_sel]) begin
          w_wr_en_next = 1'b1;
          w_din_next   = src_din_i[r_sel];
          w_to_next    = '0;
          if (r_wc == WC_W'(WORDS_PER_EVENT - 1)) begin
            w_grant_next  = '0;
            w_rr_ptr_next = w_sel_inc;
            w_gap_next    = '0;
            w_state_next  = S_GAP;
          end else begin
            w_wc_next = r_wc + 1'b1;
          end
        end else if (r_to == TO_W'(TIMEOUT - 1)) begin
          // Silent channel: abandon the event without padding.
          w_terr_next   = 1'b1;
          w_grant_next  = '0;
          w_rr_ptr_next = w_sel_inc;
          w_gap_next    = '0;
          w_state_next  = S_GAP;
        end else begin
          w_to_next = r_to + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_W'(DEAD_TIME - 1)) begin
          w_state_next = S_IDLE;
        end else begin
          w_gap_next = r_gap + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any event in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_ts_lat   <= '0;
      r_evt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_terr     <= 1'b0;
      r_grant    <= '0;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
      r_wc       <= '0;
      r_to       <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_ts_lat   <= w_ts_lat_next;
      r_evt_cnt  <= w_evt_next;
      r_drop_cnt <= w_drop_next;
      r_terr     <= w_terr_next;
      r_grant    <= w_grant_next;
      r_wr_en    <= w_wr_en_next;
      r_din      <= w_din_next;
      r_wc       <= w_wc_next;
      r_to       <= w_to_next;
      r_gap      <= w_gap_next;
    end
  end

  // Free-running 32-bit timestamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
    end
  end

endmodule
